// File: rtl/dram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, requester ids and the
// native SDRAM word-address width.
package dram_arb_pkg;

  localparam int unsigned DRAM_ADDR_W = 25;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_VGA,
    REQ_LD,
    REQ_CPU
  } req_id_e;

endpackage

// File: rtl/dram_arb_pick.sv
// Winner select for the SDRAM arbiter: fixed priority VGA > loader > CPU, with a
// starvation counter that forces a CPU grant after STARVE_MAX bypasses.
module dram_arb_pick
  import dram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    grant_i,
  input  logic    vga_req_i,
  input  logic    ld_req_i,
  input  logic    cpu_req_i,
  output req_id_e winner_o
);

  localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q, starve_d;

  always_comb begin
    winner_o = REQ_NONE;
    if (cpu_req_i && (starve_q == CNT_MAX)) winner_o = REQ_CPU;
    else if (vga_req_i)                     winner_o = REQ_VGA;
    else if (ld_req_i)                      winner_o = REQ_LD;
    else if (cpu_req_i)                     winner_o = REQ_CPU;
  end

  // Counts only grants that bypass a waiting CPU; saturates at CNT_MAX.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_req_i) begin
      starve_d = '0;
    end else if (grant_i) begin
      if (winner_o == REQ_CPU)      starve_d = '0;
      else if (starve_q != CNT_MAX) starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

endmodule

// File: rtl/dram_arbiter.sv
// Arbiter sharing the single sdram_ctl command port between VGA burst reads,
// the UART loader and the CPU; one command in flight, ack routed to the winner.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DRAM_ADDR_W,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              timeout_err,
  output logic              dram_start,
  output logic              dram_we,
  output logic              dram_burst,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  input  logic [DATA_W-1:0] dram_rdata,
  input  logic              dram_done,
  input  logic              dram_ready
);

  localparam int unsigned TMO_W = ($clog2(TIMEOUT) > 10) ? $clog2(TIMEOUT) : 10;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  req_id_e             id_q, id_d, winner;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                we_q, we_d, burst_q, burst_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                grant;

  dram_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .grant_i   (grant),
    .vga_req_i (vga_req),
    .ld_req_i  (ld_req),
    .cpu_req_i (cpu_req),
    .winner_o  (winner)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    burst_d = burst_q;
    rdata_d = rdata_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    grant   = 1'b0;
    unique case (state_q)
      S_INIT: if (dram_ready) state_d = S_IDLE;
      S_IDLE: begin
        if (winner != REQ_NONE) begin
          grant   = 1'b1;
          id_d    = winner;
          state_d = S_ISSUE;
          unique case (winner)
            REQ_VGA: begin
              addr_d = vga_addr; we_d = 1'b0; burst_d = 1'b1; wdata_d = '0;
            end
            REQ_LD: begin
              addr_d = ld_addr; we_d = 1'b1; burst_d = 1'b0; wdata_d = ld_data;
            end
            default: begin
              addr_d = cpu_addr; we_d = cpu_we; burst_d = 1'b0; wdata_d = cpu_wdata;
            end
          endcase
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      // A timed-out command still finishes through S_DONE so its requester is acked.
      S_WAIT: begin
        if (dram_done) begin
          if ((id_q == REQ_CPU) && !we_q) rdata_d = dram_rdata;
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      id_q    <= REQ_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      rdata_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      burst_q <= burst_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign dram_start  = (state_q == S_ISSUE);
  assign vga_ack     = (state_q == S_DONE) && (id_q == REQ_VGA);
  assign ld_ack      = (state_q == S_DONE) && (id_q == REQ_LD);
  assign cpu_ack     = (state_q == S_DONE) && (id_q == REQ_CPU);
  assign dram_we     = we_q;
  assign dram_burst  = burst_q;
  assign dram_addr   = addr_q;
  assign dram_wdata  = wdata_q;
  assign cpu_rdata   = rdata_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small behavioural sdram_ctl model.
module tb_dram_arbiter;

  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          vga_req, ld_req, cpu_req, cpu_we;
  logic [AW-1:0] vga_addr, ld_addr, cpu_addr;
  logic [DW-1:0] ld_data, cpu_wdata, cpu_rdata;
  logic          vga_ack, ld_ack, cpu_ack, timeout_err;
  logic          dram_start, dram_we, dram_burst;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wdata;
  logic [DW-1:0] dram_rdata = '0;
  logic          dram_done  = 1'b0;
  logic          dram_ready;

  dram_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4),
    .TIMEOUT    (1023)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_req     (vga_req),
    .vga_addr    (vga_addr),
    .vga_ack     (vga_ack),
    .ld_req      (ld_req),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ack      (ld_ack),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .timeout_err (timeout_err),
    .dram_start  (dram_start),
    .dram_we     (dram_we),
    .dram_burst  (dram_burst),
    .dram_addr   (dram_addr),
    .dram_wdata  (dram_wdata),
    .dram_rdata  (dram_rdata),
    .dram_done   (dram_done),
    .dram_ready  (dram_ready)
  );

  always #5 clk = ~clk;

  // sdram_ctl model: answers lat cycles after the start strobe unless disabled
  int            mdl_lat  = 8;
  bit            mdl_en   = 1'b1;
  logic [DW-1:0] mdl_data = 16'hBEEF;
  int            mdl_cnt  = 0;
  bit            mdl_busy = 1'b0;

  always @(posedge clk) begin
    dram_done <= 1'b0;
    if (rst) begin
      mdl_busy <= 1'b0;
      mdl_cnt  <= 0;
    end else if (dram_start) begin
      mdl_busy <= 1'b1;
      mdl_cnt  <= mdl_lat;
    end else if (mdl_busy) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_busy <= 1'b0;
        if (mdl_en) begin
          dram_done  <= 1'b1;
          dram_rdata <= mdl_data;
        end
      end
    end
  end

  typedef struct packed {
    logic          burst;
    logic          we;
    logic [AW-1:0] addr;
  } cmd_t;
  cmd_t starts[$];

  always @(posedge clk)
    if (!rst && dram_start) starts.push_back('{burst: dram_burst, we: dram_we, addr: dram_addr});

  int errors = 0;
  int checks = 0;
  int n_vga_ack = 0, n_ld_ack = 0, n_cpu_ack = 0;
  bit keep_vga = 1'b0, keep_ld = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle; requesters drop their level request on seeing their ack.
  task automatic step();
    @(negedge clk);
    if (vga_ack) begin n_vga_ack++; if (!keep_vga) vga_req = 1'b0; end
    if (ld_ack)  begin n_ld_ack++;  if (!keep_ld)  ld_req  = 1'b0; end
    if (cpu_ack) begin n_cpu_ack++; cpu_req = 1'b0; end
  endtask

  task automatic wait_start(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (dram_start) begin n = i; return; end
    end
  endtask

  task automatic wait_starts(input int cnt, input int maxc);
    for (int i = 0; i < maxc && starts.size() < cnt; i++) step();
    check("starts_count", starts.size(), cnt);
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && (vga_req || ld_req || cpu_req); i++) step();
    check("drained", {29'd0, vga_req, ld_req, cpu_req}, 0);
    repeat (3) step();
  endtask

  int n, k, dn, k0, acks_before;
  bit err_early;

  initial begin
    rst = 1'b1; dram_ready = 1'b0;
    vga_req = 0; ld_req = 0; cpu_req = 0; cpu_we = 0;
    vga_addr = 25'h100; ld_addr = 25'h200; cpu_addr = 25'h000123;
    ld_data = 16'h5A5A; cpu_wdata = 16'hC0DE;
    repeat (2) @(negedge clk);
    check("rst_start", dram_start, 0);
    check("rst_acks", {vga_ack, ld_ack, cpu_ack}, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_addr", dram_addr, 0);
    check("rst_ctrl", {dram_we, dram_burst}, 0);
    rst = 1'b0;

    // 1: no command while sdram_ctl is still initialising
    cpu_req = 1'b1;
    repeat (100) step();
    check("init_no_start", starts.size(), 0);
    dram_ready = 1'b1;
    wait_start(10, n);
    check("ready_to_start", n, 2);

    // 2: CPU read with data returned by the model
    check("cpu_rd_addr", dram_addr, 32'h123);
    check("cpu_rd_ctrl", {dram_we, dram_burst}, 0);
    dn = -100; k = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (dram_done) dn = i;
      if (cpu_ack) begin k = i; break; end
    end
    check("done_to_ack", k - dn, 1);
    check("cpu_rdata", cpu_rdata, 16'hBEEF);
    step();
    check("cpu_ack_pulse", cpu_ack, 0);
    check("cpu_rdata_hold", cpu_rdata, 16'hBEEF);
    repeat (2) step();

    // 3: simultaneous requests; CPU write this time
    mdl_lat = 3; starts.delete();
    cpu_addr = 25'h300; cpu_we = 1'b1;
    vga_req = 1; ld_req = 1; cpu_req = 1;
    wait_starts(3, 100);
    if (starts.size() >= 3) begin
      check("g1_vga", starts[0], {1'b1, 1'b0, 25'h100});
      check("g2_ld",  starts[1], {1'b0, 1'b1, 25'h200});
      check("g3_cpu", starts[2], {1'b0, 1'b1, 25'h300});
    end
    drain(100);
    check("rdata_not_on_write", cpu_rdata, 16'hBEEF);

    // 4: VGA and loader saturate the port; CPU must win the 5th grant
    starts.delete(); cpu_we = 1'b0; mdl_data = 16'h1357;
    keep_vga = 1; keep_ld = 1;
    vga_req = 1; ld_req = 1; cpu_req = 1;
    wait_starts(5, 200);
    if (starts.size() >= 5) begin
      check("starve_g4", starts[3].addr, 25'h100);
      check("starve_g5", starts[4].addr, 25'h300);
    end
    keep_vga = 0; keep_ld = 0;
    drain(300);
    check("starve_rdata", cpu_rdata, 16'h1357);

    // 5: model never completes -> timeout ack and sticky error
    mdl_en = 1'b0; ld_addr = 25'h2AA; ld_data = 16'h1234;
    acks_before = n_ld_ack;
    ld_req = 1'b1;
    wait_start(20, n);
    check("tmo_wdata", dram_wdata, 16'h1234);
    check("tmo_ctrl", {dram_we, dram_burst}, 2'b10);
    k = -1; err_early = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (ld_ack) begin k = i; break; end
      if (timeout_err) err_early = 1'b1;
    end
    check("tmo_early_err", err_early, 0);
    check("tmo_ack_delay", k, 1024);
    check("tmo_err_set", timeout_err, 1);
    repeat (20) step();
    check("tmo_err_sticky", timeout_err, 1);
    check("tmo_one_ack", n_ld_ack - acks_before, 1);

    // 6: reset in the middle of a command
    mdl_en = 1'b1; mdl_lat = 20;
    cpu_addr = 25'h0ABCDE; cpu_req = 1'b1;
    wait_start(20, n);
    repeat (5) step();
    rst = 1'b1;
    #1;
    check("rst_mid_addr", dram_addr, 0);
    check("rst_mid_terr", timeout_err, 0);
    check("rst_mid_out", {dram_start, dram_we, dram_burst, cpu_ack}, 0);
    dram_ready = 1'b0;
    acks_before = n_cpu_ack;
    starts.delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    check("rst_no_stale_ack", n_cpu_ack - acks_before, 0);
    check("rst_wait_ready", starts.size(), 0);
    dram_ready = 1'b1;
    wait_start(10, n);
    check("rst_ready_start", n, 2);
    check("rst_reissue_addr", dram_addr, 25'h0ABCDE);
    drain(60);
    check("rst_one_ack", n_cpu_ack - acks_before, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
